cam_capture_rgb444: RTL and testbench

Captures one OV7670 frame in RGB444 format into the frame-buffer BRAM write port. It sits directly upstream of the VGA display stage.
- Camera pins (pclk, vsync, href, data) are oversampled in the system clock domain.
- Each byte pair is packed into a 12-bit pixel and written at a linear address.
- display_enable is raised once a complete frame is in memory.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/cam_capture_rgb444_if.sv | 11 +
 rtl/cam_input_sync.sv | 68 ++++++
 rtl/cam_capture_rgb444.sv | 142 ++++++++++++++
 tb/tb_cam_capture_rgb444.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 RGB444 capture block: FSM states, frame
// geometry defaults and the 12-bit pixel layout.
package cam_pkg;

    localparam int H_ACTIVE_DEF     = 640;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int FRAME_PIXELS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;

    localparam int PIX_W = 12;
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VSYNC,
        ST_CAPTURE,
        ST_DONE
    } cam_state_t;

    // First camera byte carries R in its low nibble, second byte is {G,B}.
    function automatic logic [PIX_W-1:0] pack_rgb444(input logic [3:0] r,
                                                     input logic [7:0] gb);
        logic [PIX_W-1:0] p;
        p             = '0;
        p[R_LSB +: 4] = r;
        p[G_LSB +: 4] = gb[7:4];
        p[B_LSB +: 4] = gb[3:0];
        return p;
    endfunction

endpackage

// File: rtl/cam_capture_rgb444_if.sv
// Frame-buffer BRAM write port bundle driven by the capture block.
interface cam_capture_rgb444_if #(
    parameter int ADDR_W = 19
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [cam_pkg::PIX_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/cam_input_sync.sv
// Synchronises the raw camera pins into clk and produces single-cycle edge
// pulses; all pins share one pipeline so they stay cycle-aligned.
module cam_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic [7:0] data_s,
    output logic       href_s,
    output logic       href_d,
    output logic       pclk_rise,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic       href_fall
);

    localparam int BUS_W = 11;

    logic [BUS_W-1:0] synced;
    logic             pclk_prev_reg;
    logic             vsync_prev_reg;
    logic             href_prev_reg;

    // Bus layout: {pclk, vsync, href, data[7:0]}
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic [BUS_W-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) q_reg <= '0;
                    else     q_reg <= {cam_pclk, cam_vsync, cam_href, cam_data};
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) q_reg <= '0;
                    else     q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign synced = g_stage[SYNC_STAGES-1].q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_prev_reg  <= 1'b0;
            vsync_prev_reg <= 1'b0;
            href_prev_reg  <= 1'b0;
        end else begin
            pclk_prev_reg  <= synced[10];
            vsync_prev_reg <= synced[9];
            href_prev_reg  <= synced[8];
        end
    end

    assign data_s     = synced[7:0];
    assign href_s     = synced[8];
    assign href_d     = href_prev_reg;
    assign pclk_rise  =  synced[10] & ~pclk_prev_reg;
    assign vsync_rise =  synced[9]  & ~vsync_prev_reg;
    assign vsync_fall = ~synced[9]  &  vsync_prev_reg;
    assign href_fall  = ~synced[8]  &  href_prev_reg;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670 RGB444 frame capture into the frame-buffer BRAM write port.
// Build option CAM_CONTINUOUS_EN: re-arm automatically after every frame.
module cam_capture_rgb444
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ADDR_W      = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    cam_capture_rgb444_if.master wr_bus,
    output logic       busy,
    output logic       frame_done,
    output logic       display_enable,
    output logic       line_err
);

    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int LCNT_W       = $clog2(H_ACTIVE + 1) + 1;

    logic [7:0] data_s;
    logic       href_s, href_d;
    logic       pclk_rise, vsync_rise, vsync_fall, href_fall;

    cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .data_s     (data_s),
        .href_s     (href_s),
        .href_d     (href_d),
        .pclk_rise  (pclk_rise),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall)
    );

    cam_state_t        state_reg, state_next;
    logic              phase_reg;
    logic [3:0]        r_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              full_reg;
    logic [LCNT_W-1:0] line_cnt_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [PIX_W-1:0]  wr_data_reg;
    logic              line_err_reg;
    logic              disp_en_reg;

    logic              byte_strobe, pix_done, arm;
    logic [LCNT_W:0]   line_cnt_cmp;

    // A byte landing on the href falling edge still belongs to the line,
    // and one landing on the rising edge already does.
    always_comb begin
        byte_strobe  = (state_reg == ST_CAPTURE) && pclk_rise && (href_s || href_d);
        pix_done     = byte_strobe && phase_reg;
        line_cnt_cmp = {1'b0, line_cnt_reg} + {{LCNT_W{1'b0}}, pix_done};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:       if (start)      state_next = ST_WAIT_VSYNC;
            ST_WAIT_VSYNC: if (vsync_fall) state_next = ST_CAPTURE;
            ST_CAPTURE:    if (vsync_rise) state_next = ST_DONE;
`ifdef CAM_CONTINUOUS_EN
            ST_DONE:                       state_next = ST_WAIT_VSYNC;
`else
            ST_DONE:                       state_next = ST_IDLE;
`endif
            default:                       state_next = ST_IDLE;
        endcase
        arm = (state_next == ST_WAIT_VSYNC) && (state_reg != ST_WAIT_VSYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= 1'b0;
            r_reg        <= '0;
            cnt_reg      <= '0;
            full_reg     <= 1'b0;
            line_cnt_reg <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            line_err_reg <= 1'b0;
            disp_en_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= 1'b0;
            if (arm) begin
                cnt_reg      <= '0;
                full_reg     <= 1'b0;
                phase_reg    <= 1'b0;
                line_cnt_reg <= '0;
            end else if (state_reg == ST_CAPTURE) begin
                if (byte_strobe && !phase_reg) begin
                    r_reg     <= data_s[3:0];
                    phase_reg <= 1'b1;
                end else if (pix_done) begin
                    phase_reg <= 1'b0;
                    // Past the frame size pixels are silently dropped.
                    if (!full_reg) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= cnt_reg;
                        wr_data_reg <= pack_rgb444(r_reg, data_s);
                        if (cnt_reg == ADDR_W'(FRAME_PIXELS - 1)) full_reg <= 1'b1;
                        else                                     cnt_reg  <= cnt_reg + ADDR_W'(1);
                    end
                    if (line_cnt_reg != '1) line_cnt_reg <= line_cnt_reg + LCNT_W'(1);
                end
                if (href_fall) begin
                    phase_reg    <= 1'b0;
                    line_cnt_reg <= '0;
                    if (line_cnt_cmp != (LCNT_W+1)'(H_ACTIVE)) line_err_reg <= 1'b1;
                end
            end
            if (state_reg == ST_DONE) disp_en_reg <= 1'b1;
        end
    end

    assign wr_bus.wr_en    = wr_en_reg;
    assign wr_bus.wr_addr  = wr_addr_reg;
    assign wr_bus.wr_data  = wr_data_reg;
    assign busy            = (state_reg == ST_WAIT_VSYNC) || (state_reg == ST_CAPTURE);
    assign frame_done      = (state_reg == ST_DONE);
    assign display_enable  = disp_en_reg;
    assign line_err        = line_err_reg;

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Self-checking bench for cam_capture_rgb444 with a tiny 4x2 frame and a
// behavioural camera/frame model.
module tb_cam_capture_rgb444;

    localparam int H      = 4;
    localparam int V      = 2;
    localparam int AW     = 3;
    localparam int FRAME  = H * V;
`ifdef CAM_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cam_pclk = 1'b0;
    logic       cam_vsync = 1'b1;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic       busy, frame_done, display_enable, line_err;

    cam_capture_rgb444_if #(.ADDR_W(AW)) wr_if ();

    cam_capture_rgb444 #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cam_pclk       (cam_pclk),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_data       (cam_data),
        .wr_bus         (wr_if),
        .busy           (busy),
        .frame_done     (frame_done),
        .display_enable (display_enable),
        .line_err       (line_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Frame description: bytes per line as the camera will send them.
    logic [7:0]  frm [4][16];
    int          frm_len [4];
    int          frm_lines;

    int          exp_addr[$];
    logic [11:0] exp_data[$];
    bit          exp_err;

    int          got_addr[$];
    logic [11:0] got_data[$];
    int          done_cnt;
    int          max_addr;

    always @(negedge clk) begin
        if (wr_if.wr_en) begin
            got_addr.push_back(int'(wr_if.wr_addr));
            got_data.push_back(wr_if.wr_data);
            if (int'(wr_if.wr_addr) > max_addr) max_addr = int'(wr_if.wr_addr);
        end
        if (frame_done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        max_addr = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    task automatic cam_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(4);
        cam_pclk = 1'b1;
        tick(4);
        cam_pclk = 1'b0;
    endtask

    task automatic fill_random(input int lines, input int len);
        frm_lines = lines;
        for (int l = 0; l < lines; l++) begin
            frm_len[l] = len;
            for (int b = 0; b < len; b++) frm[l][b] = 8'($urandom);
        end
    endtask

    // Reference: floor(bytes/2) pixels per line, RGB444 = {b0[3:0], b1},
    // linear addresses, anything beyond the frame size dropped.
    task automatic model_frame();
        int n;
        n = 0;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        for (int l = 0; l < frm_lines; l++) begin
            int px;
            px = frm_len[l] / 2;
            if (px != H) exp_err = 1'b1;
            for (int p = 0; p < px; p++) begin
                logic [7:0] b0, b1;
                b0 = frm[l][2*p];
                b1 = frm[l][2*p+1];
                if (n < FRAME) begin
                    exp_addr.push_back(n);
                    exp_data.push_back({b0[3:0], b1});
                    n++;
                end
            end
        end
    endtask

    task automatic send_frame();
        cam_vsync = 1'b1;
        tick(10);
        cam_vsync = 1'b0;
        tick(12);
        for (int l = 0; l < frm_lines; l++) begin
            cam_href = 1'b1;
            tick(2);
            for (int b = 0; b < frm_len[l]; b++) cam_byte(frm[l][b]);
            tick(2);
            cam_href = 1'b0;
            tick(12);
        end
        cam_vsync = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (wr_if.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", wr_if.wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
        checks++; if (display_enable !== 1'b0) begin failures++; $display("FAIL reset_display_enable got=%0b exp=0", display_enable); end
        checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL reset_line_err got=%0b exp=0", line_err); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_frame_basic();
        frm_lines = 2;
        for (int l = 0; l < 2; l++) begin
            frm_len[l] = 8;
            for (int b = 0; b < 8; b++) frm[l][b] = (b % 2 == 0) ? 8'h0A : 8'hBC;
        end
        model_frame();
        clear_obs();
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_armed got=%0b exp=1", busy); end
        send_frame();
        checks++; if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL basic_write%0d got=%0d:%03h exp=%0d:%03h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_frame_done got=%0d exp=1", done_cnt); end
        checks++; if (display_enable !== 1'b1) begin failures++; $display("FAIL basic_display_enable got=%0b exp=1", display_enable); end
        checks++; if (line_err !== exp_err) begin failures++; $display("FAIL basic_line_err got=%0b exp=%0b", line_err, exp_err); end
        checks++; if (busy !== CONT) begin failures++; $display("FAIL basic_busy_after got=%0b exp=%0b", busy, CONT); end
        $display("test_frame_basic: %0d writes, %0d frame_done", got_addr.size(), done_cnt);
    endtask

    task automatic test_random_frame();
        fill_random(2, 8);
        model_frame();
        clear_obs();
        pulse_start();
        send_frame();
        checks++; if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL rand_write%0d got=%0d:%03h exp=%0d:%03h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand_frame_done got=%0d exp=1", done_cnt); end
        $display("test_random_frame: %0d writes", got_addr.size());
    endtask

    task automatic test_odd_line();
        do_reset();
        fill_random(2, 8);
        frm_len[0] = 7;
        model_frame();
        clear_obs();
        pulse_start();
        checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL odd_line_err_before got=%0b exp=0", line_err); end
        send_frame();
        checks++; if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL odd_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL odd_write%0d got=%0d:%03h exp=%0d:%03h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (line_err !== exp_err) begin failures++; $display("FAIL odd_line_err got=%0b exp=%0b", line_err, exp_err); end
        $display("test_odd_line: %0d writes, line_err=%0b", got_addr.size(), line_err);
    endtask

    task automatic test_mid_frame_start();
        do_reset();
        clear_obs();
        cam_vsync = 1'b0;
        tick(6);
        cam_href = 1'b1;
        tick(2);
        for (int b = 0; b < 3; b++) cam_byte(8'($urandom));
        pulse_start();
        for (int b = 0; b < 3; b++) cam_byte(8'($urandom));
        tick(2);
        cam_href = 1'b0;
        tick(12);
        checks++; if (got_addr.size() != 0) begin failures++; $display("FAIL midstart_early_writes got=%0d exp=0", got_addr.size()); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midstart_busy got=%0b exp=1", busy); end
        fill_random(2, 8);
        model_frame();
        send_frame();
        checks++; if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL midstart_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL midstart_write%0d got=%0d:%03h exp=%0d:%03h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        $display("test_mid_frame_start: %0d writes after arming", got_addr.size());
    endtask

    task automatic test_overflow();
        do_reset();
        fill_random(3, 8);
        model_frame();
        clear_obs();
        pulse_start();
        send_frame();
        checks++; if (got_addr.size() != FRAME) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_addr.size(), FRAME); end
        checks++; if (max_addr != FRAME - 1) begin failures++; $display("FAIL ovf_max_addr got=%0d exp=%0d", max_addr, FRAME - 1); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL ovf_write%0d got=%0d:%03h exp=%0d:%03h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL ovf_line_err got=%0b exp=0", line_err); end
        checks++; if (wr_if.wr_addr !== AW'(FRAME - 1)) begin failures++; $display("FAIL ovf_addr_hold got=%0d exp=%0d", wr_if.wr_addr, FRAME - 1); end
        $display("test_overflow: %0d writes, max addr %0d", got_addr.size(), max_addr);
    endtask

    task automatic test_rst_mid_frame();
        checks++; if (display_enable !== 1'b1) begin failures++; $display("FAIL rstmid_precond_display got=%0b exp=1", display_enable); end
        clear_obs();
        pulse_start();
        cam_vsync = 1'b1;
        tick(10);
        cam_vsync = 1'b0;
        tick(12);
        cam_href = 1'b1;
        tick(2);
        for (int b = 0; b < 8; b++) cam_byte(8'($urandom));
        tick(2);
        cam_href = 1'b0;
        tick(12);
        cam_href = 1'b1;
        tick(2);
        for (int b = 0; b < 3; b++) cam_byte(8'($urandom));
        cam_data = 8'($urandom);
        tick(4);
        cam_pclk = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        checks++; if (wr_if.wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_wr_en got=%0b exp=0", wr_if.wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        checks++; if (display_enable !== 1'b0) begin failures++; $display("FAIL rstmid_display got=%0b exp=0", display_enable); end
        rst = 1'b0;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        cam_vsync = 1'b1;
        clear_obs();
        tick(20);
        checks++; if (got_addr.size() != 0) begin failures++; $display("FAIL rstmid_stray_writes got=%0d exp=0", got_addr.size()); end
        fill_random(2, 8);
        model_frame();
        pulse_start();
        send_frame();
        checks++; if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL rstmid_write%0d got=%0d:%03h exp=%0d:%03h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        $display("test_rst_mid_frame: fresh capture %0d writes", got_addr.size());
    endtask

`ifdef CAM_CONTINUOUS_EN
    task automatic test_continuous();
        int total_done;
        total_done = 0;
        do_reset();
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            fill_random(2, 8);
            model_frame();
            clear_obs();
            send_frame();
            total_done += done_cnt;
            checks++; if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL cont_f%0d_count got=%0d exp=%0d", f, got_addr.size(), exp_addr.size()); end
            for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
                checks++;
                if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    failures++; $display("FAIL cont_f%0d_write%0d got=%0d:%03h exp=%0d:%03h", f, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
            $display("test_continuous: frame %0d, %0d writes", f, got_addr.size());
        end
        checks++; if (total_done != 3) begin failures++; $display("FAIL cont_frame_done got=%0d exp=3", total_done); end
    endtask
`endif

    initial begin
        clear_obs();
        tick(4);
        rst = 1'b0;
        tick(1);
        test_reset();
        test_frame_basic();
        test_random_frame();
        test_odd_line();
        test_mid_frame_start();
        test_overflow();
        test_rst_mid_frame();
`ifdef CAM_CONTINUOUS_EN
        test_continuous();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
